// File: rtl/derandomizer_pkg.sv
// Shared constants and helpers for the Gold-sequence derandomizer.
// Contents: symbol width, LFSR seeds, feedback and key tap masks, the FSM
// state type with its state constants, and the LFSR/key helper functions that
// are also reused by the transmit-side randomizer.
package derandomizer_pkg;

   localparam int unsigned SYM_W  = 2;
   localparam int unsigned LFSR_W = 18;
   localparam int unsigned CNT_W  = 16;

   localparam logic [LFSR_W-1:0] X_SEED = 18'h00001;
   localparam logic [LFSR_W-1:0] Y_SEED = 18'h3FFFF;

   // Feedback taps: x uses bits 7,0; y uses bits 10,7,5,0.
   localparam logic [LFSR_W-1:0] X_FB_TAPS  = 18'h00081;
   localparam logic [LFSR_W-1:0] Y_FB_TAPS  = 18'h004A1;
   // Key bit1 taps: x bits 4,6,15; y bits 5,6,8..15.
   localparam logic [LFSR_W-1:0] X_KEY_TAPS = 18'h08050;
   localparam logic [LFSR_W-1:0] Y_KEY_TAPS = 18'h0FF60;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   // Right-shifting Fibonacci LFSR step; the parity of the tapped bits enters at the MSB.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] taps);
      return {^(s & taps), s[LFSR_W-1:1]};
   endfunction

   function automatic logic [SYM_W-1:0] gold_key(input logic [LFSR_W-1:0] x,
                                                 input logic [LFSR_W-1:0] y);
      return {(^(x & X_KEY_TAPS)) ^ (^(y & Y_KEY_TAPS)), x[0] ^ y[0]};
   endfunction

endpackage

// File: rtl/derandomizer_gold_seq_gen.sv
// gold_seq_gen: pair of 18-bit LFSRs (x, y) producing a 2-bit Gold key per step.
// Shared between the randomizer and the derandomizer so both ends agree.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset, returns x/y to their seeds
//   load    - take the key from the seed state and restart the sequence from it
//   advance - step the sequence once (after the load when both are set)
//   key     - key for the current step (seed key while load is high)
module gold_seq_gen
   import derandomizer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   output logic [SYM_W-1:0] key
);

   logic [LFSR_W-1:0] x_q, y_q;
   logic [LFSR_W-1:0] x_base, y_base;

   // Loading behaves as if the registers already held the seeds, so the key
   // and the following step both come from the seed state in the same cycle.
   always_comb begin
      x_base = load ? X_SEED : x_q;
      y_base = load ? Y_SEED : y_q;
      key    = gold_key(x_base, y_base);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q <= X_SEED;
         y_q <= Y_SEED;
      end else if (advance) begin
         x_q <= lfsr_next(x_base, X_FB_TAPS);
         y_q <= lfsr_next(y_base, Y_FB_TAPS);
      end else if (load) begin
         x_q <= X_SEED;
         y_q <= Y_SEED;
      end
   end

endmodule

// File: rtl/derandomizer.sv
// derandomizer: strips the Gold-sequence scrambling from a framed stream of
// 2-bit symbols. A frame starts on i_sof, lasts FRAME_SYMS symbols, and the
// generator restarts from its seeds at every i_sof. Symbols outside a frame
// are dropped. One-deep registered output with valid/ready handshake.
// Ports:
//   i_clk, i_reset             - clock, synchronous active-high reset
//   i_valid, i_data, i_sof     - upstream symbol, start-of-frame marker
//   o_ready                    - upstream may transfer (!o_valid || i_ready)
//   o_valid, o_data            - derandomized symbol
//   o_sof, o_eof               - first / last symbol of a frame
//   i_ready                    - downstream accepts
//   o_resync_cnt               - drop + resync event count (saturating)
// Build option: define DERANDOMIZER_STATS_EN to include the event counter;
// otherwise o_resync_cnt is tied to zero.
module derandomizer
   import derandomizer_pkg::*;
#(
   parameter int unsigned FRAME_SYMS = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   input  logic [SYM_W-1:0] i_data,
   input  logic             i_sof,
   output logic             o_ready,
   output logic             o_valid,
   output logic [SYM_W-1:0] o_data,
   output logic             o_sof,
   output logic             o_eof,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_resync_cnt
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SYMS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
   logic             accept, out_xfer;
   logic             gen_load, gen_adv;
   logic             emit, sof_d, eof_d;
   logic [SYM_W-1:0] key;

   always_comb begin
      o_ready  = !o_valid || i_ready;
      accept   = i_valid && o_ready;
      out_xfer = o_valid && i_ready;
   end

   always_comb begin
      state_d   = state_q;
      sym_cnt_d = sym_cnt_q;
      gen_load  = 1'b0;
      gen_adv   = 1'b0;
      emit      = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      if (accept) begin
         if (i_sof) begin
            // Start or restart a frame; symbol 0 is never the last one.
            gen_load  = 1'b1;
            gen_adv   = 1'b1;
            emit      = 1'b1;
            sof_d     = 1'b1;
            sym_cnt_d = CNT_W'(1);
            state_d   = ST_RUN;
         end else if (state_q == ST_RUN) begin
            gen_adv = 1'b1;
            emit    = 1'b1;
            if (sym_cnt_q == LAST_IDX) begin
               eof_d     = 1'b1;
               sym_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               sym_cnt_d = sym_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         sym_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sym_cnt_q <= sym_cnt_d;
      end
   end

   gold_seq_gen u_gen (
      .clk     (i_clk),
      .reset   (i_reset),
      .load    (gen_load),
      .advance (gen_adv),
      .key     (key)
   );

   // emit implies o_ready, so held output is never overwritten while stalled.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_sof   <= 1'b0;
         o_eof   <= 1'b0;
      end else if (emit) begin
         o_valid <= 1'b1;
         o_data  <= i_data ^ key;
         o_sof   <= sof_d;
         o_eof   <= eof_d;
      end else if (out_xfer) begin
         o_valid <= 1'b0;
      end
   end

`ifdef DERANDOMIZER_STATS_EN
   logic             stat_ev;
   logic [CNT_W-1:0] stat_q;

   // Drop (no frame open) and resync (i_sof inside a frame) are exclusive per accept.
   always_comb begin
      stat_ev = accept && (i_sof ? (state_q == ST_RUN) : (state_q == ST_IDLE));
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stat_q <= '0;
      end else if (stat_ev && (stat_q != {CNT_W{1'b1}})) begin
         stat_q <= stat_q + CNT_W'(1);
      end
   end

   assign o_resync_cnt = stat_q;
`else
   assign o_resync_cnt = '0;
`endif

endmodule

// File: tb/tb_derandomizer.sv
// Self-checking bench for derandomizer (FRAME_SYMS = 4): a directed vector
// table, a hand-written backpressure sequence, and a random phase, all watched
// by a frame-level scoreboard driven from a precomputed key table.
module tb_derandomizer;

   localparam int unsigned FRAME_SYMS = 4;
`ifdef DERANDOMIZER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid = 1'b0;
   logic [1:0]  i_data = 2'b00;
   logic        i_sof = 1'b0;
   logic        i_ready = 1'b1;
   logic        o_ready, o_valid, o_sof, o_eof;
   logic [1:0]  o_data;
   logic [15:0] o_resync_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   derandomizer #(
      .FRAME_SYMS (FRAME_SYMS)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .i_sof        (i_sof),
      .o_ready      (o_ready),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_sof        (o_sof),
      .o_eof        (o_eof),
      .i_ready      (i_ready),
      .o_resync_cnt (o_resync_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Key for frame symbol k, from the two generator recurrences.
   logic [1:0] key_tab [FRAME_SYMS];

   initial begin
      logic [17:0] x, y;
      x = 18'h00001;
      y = 18'h3FFFF;
      for (int k = 0; k < FRAME_SYMS; k++) begin
         key_tab[k] = {(x[4] ^ x[6] ^ x[15]) ^ (^{y[5], y[6], y[15:8]}), x[0] ^ y[0]};
         x = {x[7] ^ x[0], x[17:1]};
         y = {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
      end
   end

   // Scoreboard: next frame index (-1 = no frame open), pending outputs, events.
   typedef struct {
      logic [1:0] data;
      logic       sof;
      logic       eof;
   } exp_t;

   exp_t m_q[$];
   int   m_pos = -1;
   int   m_ev  = 0;
   bit   mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (i_reset) begin
            m_q.delete();
            m_pos = -1;
            m_ev  = 0;
         end else begin
            bit   m_rdy, last;
            exp_t e;
            m_rdy = (m_q.size() == 0) || i_ready;
            chk("mon_valid", o_valid, m_q.size() != 0);
            chk("mon_ready", o_ready, m_rdy);
            chk("mon_stats", o_resync_cnt, STATS ? m_ev : 0);
            if (m_q.size() != 0 && i_ready) begin
               e = m_q.pop_front();
               chk("mon_data", o_data, e.data);
               chk("mon_sof", o_sof, e.sof);
               chk("mon_eof", o_eof, e.eof);
            end
            if (i_valid && m_rdy) begin
               if (i_sof) begin
                  if (m_pos >= 0 && m_ev < 65535) m_ev++;
                  m_q.push_back('{data: i_data ^ key_tab[0], sof: 1'b1, eof: 1'b0});
                  m_pos = 1;
               end else if (m_pos >= 0) begin
                  last = (m_pos == FRAME_SYMS - 1);
                  m_q.push_back('{data: i_data ^ key_tab[m_pos], sof: 1'b0, eof: last});
                  m_pos = last ? -1 : m_pos + 1;
               end else if (m_ev < 65535) begin
                  m_ev++;
               end
            end
         end
      end
   end

   task automatic drive(input logic rst, input logic v, input logic [1:0] d,
                        input logic s, input logic r);
      i_reset = rst;
      i_valid = v;
      i_data  = d;
      i_sof   = s;
      i_ready = r;
      @(posedge clk);
      #1;
   endtask

   // Inputs applied for one edge, outputs expected right after that edge.
   typedef struct {
      logic       rst, v;
      logic [1:0] d;
      logic       sof, rdy;
      logic       ov;
      logic [1:0] od;
      logic       osof, oeof;
      int         ev;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic v, input logic [1:0] d, input logic sof,
                      input logic ov, input logic [1:0] od, input logic osof,
                      input logic oeof, input int ev);
      vecs.push_back('{rst: rst, v: v, d: d, sof: sof, rdy: 1'b1, ov: ov, od: od,
                       osof: osof, oeof: oeof, ev: ev});
   endtask

   initial begin
      // Reset, then seed keys 00, 01 on an all-zero frame.
      add(1, 0, 2'b00, 0,  0, 2'b00, 0, 0,  0);
      add(0, 1, 2'b00, 1,  1, 2'b00, 1, 0,  0);
      add(0, 1, 2'b00, 0,  1, 2'b01, 0, 0,  0);
      add(0, 1, 2'b01, 0,  1, 2'b00, 0, 0,  0);
      add(0, 1, 2'b11, 0,  1, 2'b10, 0, 1,  0);
      // Three symbols with no open frame are dropped.
      add(0, 1, 2'b10, 0,  0, 2'b10, 0, 1,  1);
      add(0, 1, 2'b10, 0,  0, 2'b10, 0, 1,  2);
      add(0, 1, 2'b10, 0,  0, 2'b10, 0, 1,  3);
      add(0, 0, 2'b00, 0,  0, 2'b10, 0, 1,  3);
      // Scrambled frame of 3,1,2,0 is recovered; afterwards back in idle.
      add(0, 1, 2'b11, 1,  1, 2'b11, 1, 0,  3);
      add(0, 1, 2'b00, 0,  1, 2'b01, 0, 0,  3);
      add(0, 1, 2'b11, 0,  1, 2'b10, 0, 0,  3);
      add(0, 1, 2'b01, 0,  1, 2'b00, 0, 1,  3);
      add(0, 0, 2'b00, 0,  0, 2'b00, 0, 1,  3);
      add(0, 1, 2'b00, 0,  0, 2'b00, 0, 1,  4);
      // i_sof at symbol 2 restarts the frame with the seed key.
      add(0, 1, 2'b00, 1,  1, 2'b00, 1, 0,  4);
      add(0, 1, 2'b00, 0,  1, 2'b01, 0, 0,  4);
      add(0, 1, 2'b10, 1,  1, 2'b10, 1, 0,  5);
      add(0, 1, 2'b00, 0,  1, 2'b01, 0, 0,  5);
      add(0, 1, 2'b00, 0,  1, 2'b01, 0, 0,  5);
      add(0, 1, 2'b00, 0,  1, 2'b01, 0, 1,  5);
      // Reset wins over a concurrent accept mid-frame.
      add(0, 1, 2'b00, 1,  1, 2'b00, 1, 0,  5);
      add(1, 1, 2'b11, 0,  0, 2'b00, 0, 0,  0);
      add(0, 1, 2'b00, 0,  0, 2'b00, 0, 0,  1);
      add(0, 1, 2'b00, 1,  1, 2'b00, 1, 0,  1);
      add(0, 1, 2'b00, 0,  1, 2'b01, 0, 0,  1);
      add(0, 0, 2'b00, 0,  0, 2'b01, 0, 0,  1);

      mon_en = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].sof, vecs[i].rdy);
         chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].ov);
         chk($sformatf("vec%0d_ready", i), o_ready, !vecs[i].ov || vecs[i].rdy);
         chk($sformatf("vec%0d_stats", i), o_resync_cnt, STATS ? vecs[i].ev : 0);
         if (vecs[i].ov || vecs[i].rst) begin
            chk($sformatf("vec%0d_data", i), o_data, vecs[i].od);
            chk($sformatf("vec%0d_sof", i), o_sof, vecs[i].osof);
            chk($sformatf("vec%0d_eof", i), o_eof, vecs[i].oeof);
         end
      end

      // Downstream stalls for 5 cycles with a symbol held in the output register.
      drive(1, 0, 2'b00, 0, 1);
      drive(0, 1, 2'b00, 1, 1);
      chk("stall_first", o_data, 2'b00);
      for (int c = 0; c < 5; c++) begin
         drive(0, 1, 2'b01, 0, 0);
         chk("stall_ready", o_ready, 1'b0);
         chk("stall_valid", o_valid, 1'b1);
         chk("stall_data", o_data, 2'b00);
         chk("stall_sof", o_sof, 1'b1);
      end
      drive(0, 1, 2'b01, 0, 1);
      chk("release_data", o_data, 2'b00);
      chk("release_sof", o_sof, 1'b0);
      drive(0, 1, 2'b10, 0, 1);
      chk("release_next", o_data, 2'b11);
      drive(0, 0, 2'b00, 0, 1);
      chk("release_drain", o_valid, 1'b0);

      // Random traffic, including mid-frame resyncs, stalls and rare resets.
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
               2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2,
               $urandom_range(0, 9) < 7);
      end
      for (int c = 0; c < 4; c++) drive(0, 0, 2'b00, 0, 1);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/derandomizer.md
DERANDOMIZER -- requirements
Module: derandomizer

Interface
REQ-001 Parameter FRAME_SYMS, default 64, meaning 2-bit symbols per frame (range 2..65535).
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 i_valid  input  1  upstream symbol valid.
REQ-005 i_data  input  2  randomized symbol.
REQ-006 i_sof  input  1  start-of-frame marker, qualified by i_valid.
REQ-007 o_ready  output  1  upstream may transfer; equals !o_valid || i_ready.
REQ-008 o_valid  output  1  derandomized symbol valid.
REQ-009 o_data  output  2  derandomized symbol.
REQ-010 o_sof / o_eof  output  1 each  first / last symbol of frame, qualified by o_valid.
REQ-011 i_ready  input  1  downstream accepts.
REQ-012 o_resync_cnt  output  16  resync/drop statistics (see Configuration).

Function
REQ-013 Accept = i_valid && o_ready; output transfer = o_valid && i_ready; all state advances only on accept.
REQ-014 Generator: x 18-bit seed 18'h00001, y 18-bit seed 18'h3FFFF; advance x <= {x[7]^x[0], x[17:1]}, y <= {y[10]^y[7]^y[5]^y[0], y[17:1]}.
REQ-015 Key bit0 = x[0]^y[0]; key bit1 = (x[4]^x[6]^x[15]) ^ (y[5]^y[6]^y[8]^y[9]^y[10]^y[11]^y[12]^y[13]^y[14]^y[15]); key from current (pre-advance) state.
REQ-016 o_data = i_data XOR key, registered; latency exactly 1 cycle from accept to o_valid.
REQ-017 FSM states IDLE, RUN; reset state IDLE.
REQ-018 IDLE, accept without i_sof: symbol dropped, no output, generator frozen, drop event counted.
REQ-019 IDLE, accept with i_sof: key taken from seed state, generator loads seed then advances once, symbol counter = 1, o_sof set on output, go RUN.
REQ-020 RUN, accept without i_sof: key from current state, generator advances, counter increments.
REQ-021 RUN, accept of symbol index FRAME_SYMS-1: o_eof set on output, counter cleared, go IDLE.
REQ-022 RUN, accept with i_sof (mid-frame): frame restarts exactly as REQ-019, resync event counted, previous frame gets no o_eof.
REQ-023 Output register holds o_data/o_sof/o_eof stable while o_valid && !i_ready.
REQ-024 Accept and output transfer in same cycle: new symbol loads, o_valid stays 1, no bubble.

Reset
REQ-025 On i_reset: FSM IDLE, counter 0, x/y to seeds, o_valid 0, o_data 2'b00, o_sof 0, o_eof 0, o_resync_cnt 0; i_reset dominates any concurrent accept.
REQ-026 Reset mid-frame discards in-flight output symbol; next frame requires i_sof.

Configuration
REQ-027 Macro DERANDOMIZER_STATS_EN defined: o_resync_cnt counts drop (REQ-018) plus resync (REQ-022) events, saturating at 16'hFFFF, one increment per event.
REQ-028 Macro undefined: counter logic absent, o_resync_cnt tied to 16'h0000; all other behaviour identical.

Structure
REQ-029 Package derandomizer_pkg holds seed constants, tap positions, FSM state typedef, symbol width constant.
REQ-030 Sub-module gold_seq_gen (load, advance, 2-bit key output) holds x/y registers; shared with the transmit-side randomizer.

Verification
REQ-031 Reset, then i_sof with symbols 2'b00, 2'b00 -> o_data 2'b00, 2'b01, o_sof on first, latency 1 cycle.
REQ-032 FRAME_SYMS=4, full frame of randomized reference stream -> original data recovered, o_eof on 4th, FSM back to IDLE.
REQ-033 Three symbols in IDLE without i_sof -> no o_valid, o_resync_cnt 3 (stats on) / 0 (stats off).
REQ-034 i_sof at symbol 2 of a frame -> output symbol 2 has o_sof and key 2'b00, no o_eof on prior frame, resync counted.
REQ-035 i_ready held low 5 cycles mid-frame -> o_ready low, o_data stable, no symbol lost or duplicated after release.
REQ-036 i_reset asserted concurrently with accept in RUN -> o_valid 0 next cycle, generator at seeds, counter 0.
